// File: rtl/pipe_pkg.sv
// Shared pipeline types for the RV32I core: control bundle, ALU op codes, register zero.
package pipe_pkg;

  localparam int ALUOP_W = 4;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 4'd0;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 4'd1;
  localparam logic [ALUOP_W-1:0] ALUOP_SLL   = 4'd2;
  localparam logic [ALUOP_W-1:0] ALUOP_SLT   = 4'd3;
  localparam logic [ALUOP_W-1:0] ALUOP_SLTU  = 4'd4;
  localparam logic [ALUOP_W-1:0] ALUOP_XOR   = 4'd5;
  localparam logic [ALUOP_W-1:0] ALUOP_SRL   = 4'd6;
  localparam logic [ALUOP_W-1:0] ALUOP_SRA   = 4'd7;
  localparam logic [ALUOP_W-1:0] ALUOP_OR    = 4'd8;
  localparam logic [ALUOP_W-1:0] ALUOP_AND   = 4'd9;
  localparam logic [ALUOP_W-1:0] ALUOP_PASSB = 4'd10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic               regwrite;
    logic               memread;
    logic               memwrite;
    logic               memtoreg;
    logic               alusrc;
    logic               branch;
    logic               jump;
    logic [ALUOP_W-1:0] aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector, purely combinational.
// Flags an ID instruction reading the destination of a load currently in EX (x0 excluded).
module hazard_detect
  import pipe_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       lu
);

  // rs2 is compared even for I-type; the occasional false stall is accepted
  assign lu = ex_valid & ex_memread & (ex_rd != REG_ZERO) & id_valid &
              ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion; 1-cycle latency, priority reset > flush > ext_stall > load-use.
// Optional load-use bubble counter on stall_cnt when STALL_CNT_EN is defined.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AOPW = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [XLEN-1:0] id_rs1data,
  input  logic [XLEN-1:0] id_rs2data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic            id_memtoreg,
  input  logic            id_alusrc,
  input  logic            id_branch,
  input  logic            id_jump,
  input  logic [AOPW-1:0] id_aluop,
  input  logic            ex_flush,
  input  logic            ext_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_rs1data,
  output logic [XLEN-1:0] ex_rs2data,
  output logic [XLEN-1:0] ex_imm,
  output logic [AOPW-1:0] ex_aluop,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_memtoreg,
  output logic            ex_alusrc,
  output logic            ex_branch,
  output logic            ex_jump,
`ifdef STALL_CNT_EN
  output logic [31:0]     stall_cnt,
`endif
  output logic            stall_if
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_rs1data;
  logic [XLEN-1:0] r_rs2data;
  logic [XLEN-1:0] r_imm;
  ctrl_t           r_ctrl;

  ctrl_t           w_ctrl_in;
  logic            w_lu;

  assign w_ctrl_in = '{regwrite: id_regwrite, memread: id_memread, memwrite: id_memwrite,
                       memtoreg: id_memtoreg, alusrc: id_alusrc, branch: id_branch,
                       jump: id_jump, aluop: ALUOP_W'(id_aluop)};

  hazard_detect u_hazard (
    .ex_valid   (r_valid),
    .ex_memread (r_ctrl.memread),
    .ex_rd      (r_rd),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .lu         (w_lu)
  );

  always_ff @(posedge CLK) begin
    if (RST || ex_flush || (!ext_stall && w_lu)) begin
      // reset, redirect and load-use bubble all load the same all-zero NOP
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_rs1     <= REG_ZERO;
      r_rs2     <= REG_ZERO;
      r_rd      <= REG_ZERO;
      r_rs1data <= '0;
      r_rs2data <= '0;
      r_imm     <= '0;
      r_ctrl    <= CTRL_NOP;
    end else if (!ext_stall) begin
      r_valid   <= id_valid;
      r_pc      <= id_pc;
      r_rs1     <= id_rs1;
      r_rs2     <= id_rs2;
      r_rd      <= id_rd;
      r_rs1data <= id_rs1data;
      r_rs2data <= id_rs2data;
      r_imm     <= id_imm;
      r_ctrl    <= id_valid ? w_ctrl_in : CTRL_NOP;
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cnt <= '0;
    end else if (!ex_flush && !ext_stall && w_lu && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign stall_if    = w_lu & ~ex_flush & ~RST;

  assign ex_valid    = r_valid;
  assign ex_pc       = r_pc;
  assign ex_rs1      = r_rs1;
  assign ex_rs2      = r_rs2;
  assign ex_rd       = r_rd;
  assign ex_rs1data  = r_rs1data;
  assign ex_rs2data  = r_rs2data;
  assign ex_imm      = r_imm;
  assign ex_aluop    = AOPW'(r_ctrl.aluop);
  assign ex_regwrite = r_ctrl.regwrite;
  assign ex_memread  = r_ctrl.memread;
  assign ex_memwrite = r_ctrl.memwrite;
  assign ex_memtoreg = r_ctrl.memtoreg;
  assign ex_alusrc   = r_ctrl.alusrc;
  assign ex_branch   = r_ctrl.branch;
  assign ex_jump     = r_ctrl.jump;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for the pipeline sequence, hand sequences for reset, hold and mid-run reset.
module tb_id_ex_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1data, id_rs2data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_branch, id_jump;
  logic [3:0]  id_aluop;
  logic        ex_flush, ext_stall;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1data, ex_rs2data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_aluop;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_branch, ex_jump;
  logic        stall_if;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  id_ex_stage #(.XLEN(32), .AOPW(4)) dut (
    .CLK(CLK), .RST(RST),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1data(id_rs1data), .id_rs2data(id_rs2data), .id_imm(id_imm),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc), .id_branch(id_branch), .id_jump(id_jump),
    .id_aluop(id_aluop), .ex_flush(ex_flush), .ext_stall(ext_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rs1data(ex_rs1data), .ex_rs2data(ex_rs2data), .ex_imm(ex_imm), .ex_aluop(ex_aluop),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc), .ex_branch(ex_branch), .ex_jump(ex_jump),
`ifdef STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .stall_if(stall_if)
  );

  typedef struct {
    logic        v;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        rw, mr, fl, st;
    logic        sif, ev;
    logic [4:0]  erd;
    logic        erw, emr;
    logic [31:0] eimm;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(logic v, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic [31:0] imm, logic rw, logic mr, logic fl, logic st,
                              logic sif, logic ev, logic [4:0] erd, logic erw, logic emr,
                              logic [31:0] eimm, logic [31:0] cnt);
    vec_t r;
    r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.imm = imm; r.rw = rw; r.mr = mr;
    r.fl = fl; r.st = st; r.sif = sif; r.ev = ev; r.erd = erd; r.erw = erw; r.emr = emr;
    r.eimm = eimm; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] imm, input logic [6:0] ctl,
                        input logic [3:0] aop);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1data = d1; id_rs2data = d2; id_imm = imm;
    {id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_branch, id_jump} = ctl;
    id_aluop = aop;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
    chk({tag, "_pc"}, ex_pc, 32'd0);
    chk({tag, "_idx"}, {17'd0, ex_rs1, ex_rs2, ex_rd}, 32'd0);
    chk({tag, "_d1"}, ex_rs1data, 32'd0);
    chk({tag, "_d2"}, ex_rs2data, 32'd0);
    chk({tag, "_imm"}, ex_imm, 32'd0);
    chk({tag, "_ctl"}, {21'd0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
                        ex_alusrc, ex_branch, ex_jump, ex_aluop}, 32'd0);
  endtask

  initial begin
    logic [31:0] hold_pc, hold_imm;
    RST = 1'b1; ex_flush = 1'b0; ext_stall = 1'b0;

    // Reset held two cycles with random ID content
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      set_id(1'b1, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom,
             $urandom, 7'($urandom), 4'($urandom));
      #1 chk("rst_stall_if", {31'd0, stall_if}, 32'd0);
      @(posedge CLK); #1;
      chk_all_zero("rst");
`ifdef STALL_CNT_EN
      chk("rst_cnt", stall_cnt, 32'd0);
`endif
    end
    @(negedge CLK); RST = 1'b0;

    //            v  rs1 rs2 rd  imm rw mr fl st   sif ev erd erw emr eimm cnt
    tbl[0]  = mk(1, 0,  0,  5,  7,  1, 0, 0, 0,   0,  1,  5,  1,  0,  7,  0); // addi x5,x0,7
    tbl[1]  = mk(1, 5,  0,  6,  0,  1, 1, 0, 0,   0,  1,  6,  1,  1,  0,  0); // lw x6
    tbl[2]  = mk(1, 1,  6,  7,  0,  1, 0, 0, 0,   1,  0,  0,  0,  0,  0,  1); // load-use on rs2
    tbl[3]  = mk(1, 1,  6,  7,  0,  1, 0, 0, 0,   0,  1,  7,  1,  0,  0,  1); // dependent enters
    tbl[4]  = mk(1, 1,  0,  0,  4,  1, 1, 0, 0,   0,  1,  0,  1,  1,  4,  1); // lw x0
    tbl[5]  = mk(1, 0,  0,  8,  9,  1, 0, 0, 0,   0,  1,  8,  1,  0,  9,  1); // x0 guard
    tbl[6]  = mk(1, 8,  0,  9,  12, 1, 1, 0, 0,   0,  1,  9,  1,  1,  12, 1); // lw x9
    tbl[7]  = mk(1, 9,  0,  10, 3,  1, 0, 1, 1,   0,  0,  0,  0,  0,  0,  1); // flush+stall+lu
    tbl[8]  = mk(0, 0,  0,  11, 5,  1, 1, 0, 0,   0,  0,  11, 0,  0,  5,  1); // invalid: ctrl forced 0
    tbl[9]  = mk(1, 0,  0,  12, 16, 1, 1, 0, 0,   0,  1,  12, 1,  1,  16, 1); // lw x12
    tbl[10] = mk(1, 12, 0,  13, 1,  1, 0, 0, 1,   1,  1,  12, 1,  1,  16, 1); // stall+lu: hold
    tbl[11] = mk(1, 12, 0,  13, 1,  1, 0, 0, 0,   1,  0,  0,  0,  0,  0,  2); // release: bubble
    tbl[12] = mk(1, 12, 0,  13, 1,  1, 0, 0, 0,   0,  1,  13, 1,  0,  1,  2);
    tbl[13] = mk(1, 0,  0,  14, 2,  1, 0, 1, 0,   0,  0,  0,  0,  0,  0,  2); // plain flush
    tbl[14] = mk(1, 0,  0,  15, 20, 1, 1, 0, 0,   0,  1,  15, 1,  1,  20, 2); // lw x15
    tbl[15] = mk(1, 0,  15, 16, 6,  1, 0, 0, 0,   1,  0,  0,  0,  0,  0,  3); // rs2 false stall
    tbl[16] = mk(1, 0,  15, 16, 6,  1, 0, 0, 0,   0,  1,  16, 1,  0,  6,  3);

    for (int i = 0; i < 17; i++) begin
      @(negedge CLK);
      set_id(tbl[i].v, 32'h100 + 32'(i) * 4, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
             32'hA000_0000 | 32'(i), 32'hB000_0000 | 32'(i), tbl[i].imm,
             {tbl[i].rw, tbl[i].mr, 5'b0}, 4'(i));
      ex_flush = tbl[i].fl; ext_stall = tbl[i].st;
      #1 chk($sformatf("v%0d_stall_if", i), {31'd0, stall_if}, {31'd0, tbl[i].sif});
      @(posedge CLK); #1;
      chk($sformatf("v%0d_valid", i), {31'd0, ex_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("v%0d_rd", i), {27'd0, ex_rd}, {27'd0, tbl[i].erd});
      chk($sformatf("v%0d_regwrite", i), {31'd0, ex_regwrite}, {31'd0, tbl[i].erw});
      chk($sformatf("v%0d_memread", i), {31'd0, ex_memread}, {31'd0, tbl[i].emr});
      chk($sformatf("v%0d_imm", i), ex_imm, tbl[i].eimm);
`ifdef STALL_CNT_EN
      chk($sformatf("v%0d_cnt", i), stall_cnt, tbl[i].cnt);
`endif
    end

    // Full pass-through of every field
    @(negedge CLK);
    ex_flush = 1'b0; ext_stall = 1'b0;
    set_id(1'b1, 32'h2000, 5'd1, 5'd2, 5'd3, 32'd11, 32'd22, 32'd33, 7'b1011111, 4'hA);
    @(posedge CLK); #1;
    chk("pt_pc", ex_pc, 32'h2000);
    chk("pt_idx", {17'd0, ex_rs1, ex_rs2, ex_rd}, {17'd0, 5'd1, 5'd2, 5'd3});
    chk("pt_d1", ex_rs1data, 32'd11);
    chk("pt_d2", ex_rs2data, 32'd22);
    chk("pt_ctl", {25'd0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc,
                   ex_branch, ex_jump}, 32'b1011111);
    chk("pt_aluop", {28'd0, ex_aluop}, 32'hA);
    hold_pc = 32'h2000; hold_imm = 32'd33;

    // ext_stall for three cycles while ID changes
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      ext_stall = 1'b1;
      set_id(1'b1, 32'h3000 + 32'(c), 5'd4, 5'd5, 5'(20 + c), 32'd44, 32'd55, 32'(70 + c),
             7'b1000000, 4'h3);
      @(posedge CLK); #1;
      chk($sformatf("hold%0d_pc", c), ex_pc, hold_pc);
      chk($sformatf("hold%0d_imm", c), ex_imm, hold_imm);
      chk($sformatf("hold%0d_rd_aop", c), {23'd0, ex_rd, ex_aluop}, {23'd0, 5'd3, 4'hA});
    end
    @(negedge CLK);
    ext_stall = 1'b0;
    set_id(1'b1, 32'h4000, 5'd6, 5'd7, 5'd8, 32'd66, 32'd77, 32'd88, 7'b1000001, 4'h5);
    @(posedge CLK); #1;
    chk("rel_pc", ex_pc, 32'h4000);
    chk("rel_rd_aop", {23'd0, ex_rd, ex_aluop}, {23'd0, 5'd8, 4'h5});
    chk("rel_imm", ex_imm, 32'd88);

    // Reset arriving while a load-use would otherwise stall
    @(negedge CLK);
    set_id(1'b1, 32'h5000, 5'd0, 5'd0, 5'd20, 32'd0, 32'd0, 32'd0, 7'b1100000, 4'h0);
    @(posedge CLK);
    @(negedge CLK);
    set_id(1'b1, 32'h5004, 5'd20, 5'd0, 5'd21, 32'd0, 32'd0, 32'd1, 7'b1000000, 4'h0);
    #1 chk("pre_rst_stall_if", {31'd0, stall_if}, 32'd1);
    RST = 1'b1;
    #1 chk("mid_rst_stall_if", {31'd0, stall_if}, 32'd0);
    @(posedge CLK); #1;
    chk_all_zero("mid_rst");
`ifdef STALL_CNT_EN
    chk("mid_rst_cnt", stall_cnt, 32'd0);
`endif
    @(negedge CLK); RST = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
